// File: rtl/vga_rx_monitor_if.sv
// rtl/vga_rx_monitor_if.sv - VGA source bus: pixel clock, sync pair and RGB
interface vga_rx_monitor_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
  modport slave  (input  VGA_CLK, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive monitor: timing reconstruction, lock FSM, frame checksum
module vga_rx_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int HS_W     = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int VS_W     = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_TOL = 1
) (
  input  logic            CLOCK_50,
  input  logic            RST,
  vga_rx_monitor_if.slave vga,
  output logic            locked,
  output logic            px_valid,
  output logic [9:0]      x,
  output logic [8:0]      y,
  output logic            frame_done,
  output logic [15:0]     frame_sum,
  output logic [10:0]     h_meas,
  output logic [9:0]      v_meas,
  output logic            err_h,
  output logic            err_v
);
  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [10:0] H_LO   = 11'(HS_W + H_BP);
  localparam logic [10:0] H_HI   = 11'(HS_W + H_BP + H_ACTIVE);
  localparam logic [10:0] HSW_LO = 11'(HS_W - SYNC_TOL);
  localparam logic [10:0] HSW_HI = 11'(HS_W + SYNC_TOL);
  localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0]  V_LO   = 10'(VS_W + V_BP);
  localparam logic [9:0]  V_HI   = 10'(VS_W + V_BP + V_ACTIVE);
  localparam logic [9:0]  VSW_LO = 10'(VS_W - SYNC_TOL);
  localparam logic [9:0]  VSW_HI = 10'(VS_W + SYNC_TOL);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} state_t;

  // Input stage: everything captured on the same CLOCK_50 edge as VGA_CLK
  logic        r_clk_s, r_clk_p, r_hs_s, r_vs_s;
  logic [7:0]  r_r_s, r_g_s, r_b_s;
  logic        r_hs, r_vs;
  logic [10:0] r_h_cnt, r_hs_w;
  logic [9:0]  r_v_cnt, r_vs_w;
  logic        r_h_seen, r_frame_hbad;
  logic [1:0]  r_good_cnt;
  logic [15:0] r_acc;
  state_t      r_state;

  logic        w_tick, w_hs_fall, w_hs_rise, w_vs_fall, w_win;
  logic        w_hlen_bad, w_hsw_bad, w_line_bad, w_frame_bad;
  logic [10:0] w_h_inc, w_h_nxt;
  logic [9:0]  w_v_inc, w_v_nxt;

  assign w_tick    = r_clk_s & ~r_clk_p;
  assign w_hs_fall = w_tick &  r_hs & ~r_hs_s;
  assign w_hs_rise = w_tick & ~r_hs &  r_hs_s;
  assign w_vs_fall = w_tick &  r_vs & ~r_vs_s;

  assign w_h_inc = (r_h_cnt == 11'h7ff) ? r_h_cnt : r_h_cnt + 11'd1;
  assign w_v_inc = (r_v_cnt == 10'h3ff) ? r_v_cnt : r_v_cnt + 10'd1;
  // Coordinates of the pixel carried by this tick: the HS-fall pixel is column 0
  assign w_h_nxt = w_hs_fall ? 11'd0 : w_h_inc;
  assign w_v_nxt = w_vs_fall ? 10'd0 : (w_hs_fall ? w_v_inc : r_v_cnt);
  assign w_win   = (w_h_nxt >= H_LO) && (w_h_nxt < H_HI) &&
                   (w_v_nxt >= V_LO) && (w_v_nxt < V_HI);

  assign w_hlen_bad  = w_hs_fall & r_h_seen & (w_h_inc != H_TOT);
  assign w_hsw_bad   = w_hs_rise & r_h_seen & ((r_hs_w < HSW_LO) || (r_hs_w > HSW_HI));
  assign w_line_bad  = w_hlen_bad | w_hsw_bad;
  assign w_frame_bad = (w_v_inc != V_TOT) || (r_vs_w < VSW_LO) || (r_vs_w > VSW_HI) ||
                       r_frame_hbad || w_line_bad;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_clk_s <= 1'b0;  r_clk_p <= 1'b0;  r_hs_s <= 1'b1;  r_vs_s <= 1'b1;
      r_r_s <= '0;  r_g_s <= '0;  r_b_s <= '0;
      r_hs <= 1'b1;  r_vs <= 1'b1;
      r_h_cnt <= '0;  r_hs_w <= '0;  r_v_cnt <= '0;  r_vs_w <= '0;
      r_h_seen <= 1'b0;  r_frame_hbad <= 1'b0;  r_good_cnt <= '0;  r_acc <= '0;
      r_state <= SEARCH;
      locked <= 1'b0;  px_valid <= 1'b0;  x <= '0;  y <= '0;
      frame_done <= 1'b0;  frame_sum <= '0;  h_meas <= '0;  v_meas <= '0;
      err_h <= 1'b0;  err_v <= 1'b0;
    end else begin
      r_clk_s <= vga.VGA_CLK;  r_clk_p <= r_clk_s;
      r_hs_s  <= vga.VGA_HS;   r_vs_s  <= vga.VGA_VS;
      r_r_s   <= vga.VGA_R;    r_g_s   <= vga.VGA_G;   r_b_s <= vga.VGA_B;
      px_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (w_tick) begin
        r_hs    <= r_hs_s;
        r_vs    <= r_vs_s;
        r_h_cnt <= w_h_nxt;
        r_v_cnt <= w_v_nxt;
        if (w_hs_fall) begin
          h_meas   <= w_h_inc;
          r_h_seen <= 1'b1;
          r_hs_w   <= 11'd1;
        end else if (!r_hs_s && r_hs_w != 11'h7ff) begin
          r_hs_w <= r_hs_w + 11'd1;
        end
        if (w_vs_fall)
          r_vs_w <= 10'd1;
        else if (w_hs_fall && !r_vs_s && r_vs_w != 10'h3ff)
          r_vs_w <= r_vs_w + 10'd1;
        if (w_win) begin
          r_acc <= r_acc + 16'(r_r_s) + 16'(r_g_s) + 16'(r_b_s);
          if (locked) begin
            px_valid <= 1'b1;
            x        <= 10'(w_h_nxt - H_LO);
            y        <= 9'(w_v_nxt - V_LO);
          end
        end
        if (w_line_bad) begin
          r_frame_hbad <= 1'b1;
          if (r_state == LOCKED) err_h <= 1'b1;
        end
        if (w_vs_fall) begin
          v_meas       <= w_v_inc;
          r_acc        <= '0;
          r_frame_hbad <= 1'b0;
          case (r_state)
            SEARCH: begin
              r_state    <= ACQ;
              r_good_cnt <= '0;
            end
            ACQ: begin
              if (w_frame_bad) begin
                r_good_cnt <= '0;
              end else begin
                r_good_cnt <= r_good_cnt + 2'd1;
                if (r_good_cnt == 2'd1) begin
                  r_state <= LOCKED;
                  locked  <= 1'b1;
                end
              end
            end
            LOCKED: begin
              if (w_frame_bad) begin
                err_v      <= 1'b1;
                locked     <= 1'b0;
                r_state    <= ACQ;
                r_good_cnt <= '0;
              end else begin
                frame_sum  <= r_acc;
                frame_done <= 1'b1;
              end
            end
            default: r_state <= SEARCH;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - scoreboard bench for vga_rx_monitor on a scaled-down raster
module tb_vga_rx_monitor;
  localparam int H_TOTAL  = 24;
  localparam int HS_W     = 4;
  localparam int H_BP     = 3;
  localparam int H_ACTIVE = 12;
  localparam int V_TOTAL  = 14;
  localparam int VS_W     = 2;
  localparam int V_BP     = 2;
  localparam int V_ACTIVE = 6;
  localparam int SYNC_TOL = 1;
  localparam int H_LO     = HS_W + H_BP;
  localparam int V_LO     = VS_W + V_BP;

  logic        CLOCK_50 = 1'b0;
  logic        RST = 1'b1;
  logic        locked, px_valid, frame_done, err_h, err_v;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [15:0] frame_sum;
  logic [10:0] h_meas;
  logic [9:0]  v_meas;

  vga_rx_monitor_if vga ();

  vga_rx_monitor #(
    .H_TOTAL(H_TOTAL), .HS_W(HS_W), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .VS_W(VS_W), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .SYNC_TOL(SYNC_TOL)
  ) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .vga(vga),
    .locked(locked), .px_valid(px_valid), .x(x), .y(y),
    .frame_done(frame_done), .frame_sum(frame_sum),
    .h_meas(h_meas), .v_meas(v_meas), .err_h(err_h), .err_v(err_v)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          px_total = 0;
  int          fd_total = 0;
  logic [63:0] px_q[$];
  logic [63:0] sum_q[$];
  logic [63:0] mon_exp;

  // Bench model of the lock FSM, advanced at each frame start
  int          m_state = 0;
  int          m_good  = 0;
  bit          m_err_h = 1'b0;
  bit          m_err_v = 1'b0;
  bit          p_bad   = 1'b0;
  logic [15:0] p_sum   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (px_valid) begin
      px_total++;
      mon_exp = (px_q.size() > 0) ? px_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      check("px_xy", 64'({x, y}), mon_exp);
    end
    if (frame_done) begin
      fd_total++;
      mon_exp = (sum_q.size() > 0) ? sum_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
      check("frame_sum", 64'(frame_sum), mon_exp);
    end
  end

  task automatic drive_px(input logic hs, input logic vs, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b);
    @(negedge CLOCK_50);
    vga.VGA_CLK = 1'b0;
    vga.VGA_HS  = hs;
    vga.VGA_VS  = vs;
    vga.VGA_R   = r;
    vga.VGA_G   = g;
    vga.VGA_B   = b;
    @(negedge CLOCK_50);
    vga.VGA_CLK = 1'b1;
  endtask

  task automatic frame_start();
    case (m_state)
      0: begin m_state = 1; m_good = 0; end
      1: begin
        if (p_bad) m_good = 0;
        else begin
          m_good++;
          if (m_good == 2) m_state = 2;
        end
      end
      default: begin
        if (p_bad) begin m_err_v = 1'b1; m_state = 1; m_good = 0; end
        else sum_q.push_back(64'(p_sum));
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    vga.VGA_CLK = 1'b0;
    RST = 1'b1;
    @(negedge CLOCK_50);
    check("rst_outs", 64'({locked, px_valid, x, y, frame_done, frame_sum, h_meas, v_meas, err_h, err_v}), 64'd0);
    RST = 1'b0;
    m_state = 0; m_good = 0; m_err_h = 1'b0; m_err_v = 1'b0;
  endtask

  task automatic do_freeze();
    int px0, fd0;
    repeat (2) @(negedge CLOCK_50);
    px0 = px_total;
    fd0 = fd_total;
    repeat (200) begin
      @(negedge CLOCK_50);
      vga.VGA_HS = 1'($urandom);
      vga.VGA_VS = 1'($urandom);
      vga.VGA_R  = 8'($urandom);
    end
    check("freeze_px", 64'(px_total), 64'(px0));
    check("freeze_fd", 64'(fd_total), 64'(fd0));
    check("freeze_locked", 64'(locked), 64'(m_state == 2));
    check("freeze_h_meas", 64'(h_meas), 64'(H_TOTAL));
    check("freeze_v_meas", 64'(v_meas), 64'(V_TOTAL));
  endtask

  task automatic drive_frame(input int hsw, input int vsw, input int bad_line, input bit grad,
                             input int rst_line, input int freeze_line);
    int          len, px0;
    bit          bad, hs_bad, win;
    logic [7:0]  r, g, b;
    logic [15:0] sum;
    frame_start();
    px0    = px_total;
    sum    = '0;
    hs_bad = (hsw > HS_W + SYNC_TOL) || (hsw < HS_W - SYNC_TOL);
    bad    = hs_bad || (vsw > VS_W + SYNC_TOL) || (vsw < VS_W - SYNC_TOL);
    if (hs_bad && m_state == 2) m_err_h = 1'b1;
    for (int l = 0; l < V_TOTAL; l++) begin
      if (l == rst_line) do_reset();
      if (l == freeze_line) do_freeze();
      len = (l == bad_line) ? H_TOTAL + 1 : H_TOTAL;
      if (len != H_TOTAL) begin
        bad = 1'b1;
        if (m_state == 2) m_err_h = 1'b1;
      end
      for (int p = 0; p < len; p++) begin
        win = (p >= H_LO) && (p < H_LO + H_ACTIVE) && (l >= V_LO) && (l < V_LO + V_ACTIVE);
        if (win) begin
          r = grad ? 8'(p - H_LO) : 8'd1;
          g = grad ? 8'(l - V_LO) : 8'd2;
          b = grad ? 8'd0 : 8'd3;
          sum = sum + 16'(r) + 16'(g) + 16'(b);
          if (m_state == 2) px_q.push_back(64'({10'(p - H_LO), 9'(l - V_LO)}));
        end else begin
          r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
        drive_px((p < hsw) ? 1'b0 : 1'b1, (l < vsw) ? 1'b0 : 1'b1, r, g, b);
      end
    end
    p_bad = bad;
    p_sum = sum;
    repeat (3) @(negedge CLOCK_50);
    check("locked", 64'(locked), 64'(m_state == 2));
    check("err_h", 64'(err_h), 64'(m_err_h));
    check("err_v", 64'(err_v), 64'(m_err_v));
    if (rst_line < 0) begin
      check("px_count", 64'(px_total - px0), 64'((m_state == 2) ? H_ACTIVE * V_ACTIVE : 0));
      check("h_meas", 64'(h_meas), 64'(H_TOTAL));
      if (m_state == 2) check("v_meas", 64'(v_meas), 64'(V_TOTAL));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vga.VGA_CLK = 1'b0; vga.VGA_HS = 1'b1; vga.VGA_VS = 1'b1;
    vga.VGA_R = '0; vga.VGA_G = '0; vga.VGA_B = '0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_outs", 64'({locked, px_valid, x, y, frame_done, frame_sum, h_meas, v_meas, err_h, err_v}), 64'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    // Nominal constant-colour stream: acquire, lock, then checksummed frames
    for (int f = 0; f < 6; f++) drive_frame(HS_W, VS_W, -1, 1'b0, -1, -1);
    // Sync widths at both tolerance edges keep the lock
    drive_frame(HS_W + 1, VS_W + 1, -1, 1'b0, -1, -1);
    drive_frame(HS_W + 1, VS_W + 1, -1, 1'b0, -1, -1);
    drive_frame(HS_W - 1, VS_W - 1, -1, 1'b0, -1, -1);
    // One over-long line while locked, then recovery
    drive_frame(HS_W, VS_W, 5, 1'b0, -1, -1);
    for (int f = 0; f < 4; f++) drive_frame(HS_W, VS_W, -1, 1'b0, -1, -1);
    // Gradient pattern
    for (int f = 0; f < 3; f++) drive_frame(HS_W, VS_W, -1, 1'b1, -1, -1);
    // Reset mid-frame, then relock from scratch
    drive_frame(HS_W, VS_W, -1, 1'b1, 6, -1);
    for (int f = 0; f < 4; f++) drive_frame(HS_W, VS_W, -1, 1'b1, -1, -1);
    // Static pixel clock mid-frame
    drive_frame(HS_W, VS_W, -1, 1'b1, -1, 3);

    // Closing line so the last frame is judged
    frame_start();
    for (int p = 0; p < H_TOTAL; p++)
      drive_px((p < HS_W) ? 1'b0 : 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    repeat (10) @(negedge CLOCK_50);
    check("locked_end", 64'(locked), 64'(m_state == 2));
    check("px_q_left", 64'(px_q.size()), 64'd0);
    check("sum_q_left", 64'(sum_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
